// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: 8-bit unsigned binary to three-digit BCD converter.
// Double-dabble (shift-and-add-3): one bit per SHIFT cycle, 8 SHIFT
// cycles, then a single DONE cycle. The digit and blank outputs are
// registered and change only on the edge that completes the conversion.
// Optional leading-zero blanking is enabled by defining BIN2BCD_LZB_EN.
module bin2bcd_conv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [2:0] blank
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

`ifdef BIN2BCD_LZB_EN
    localparam logic [2:0] BLANK_RST = 3'b110;
`else
    localparam logic [2:0] BLANK_RST = 3'b000;
`endif

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hundreds_q, hundreds_d;
    logic [2:0]  blank_q, blank_d;

    logic [11:0] scratch_adj;
    logic [11:0] scratch_fin;
    logic        shift_out_unused;
    logic        last_shift;

    // Blank pattern for a given result: leading zeros dark when enabled.
    function automatic logic [2:0] blank_of(input logic [3:0] h, input logic [3:0] t);
`ifdef BIN2BCD_LZB_EN
        return {(h == 4'd0), (h == 4'd0) && (t == 4'd0), 1'b0};
`else
        return 3'b000;
`endif
    endfunction

    // Add-3 correction of every scratch digit that is 5 or more.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                          ? scratch_q[gi*4 +: 4] + 4'd3
                                          : scratch_q[gi*4 +: 4];
        end
    endgenerate

    // The bit shifted out of the hundreds digit is always zero for 8-bit input.
    assign {shift_out_unused, scratch_fin} = {scratch_adj, shift_q[7]};
    assign last_shift = (state_q == SHIFT) && (cnt_q == 3'd7);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Datapath next values: capture on start, shift in SHIFT, publish on the last shift.
    always_comb begin
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        hundreds_d = hundreds_q;
        blank_d    = blank_q;
        if (state_q == IDLE && start) begin
            shift_d   = bin;
            scratch_d = 12'd0;
            cnt_d     = 3'd0;
        end else if (state_q == SHIFT) begin
            shift_d   = {shift_q[6:0], 1'b0};
            scratch_d = scratch_fin;
            cnt_d     = cnt_q + 3'd1;
            if (last_shift) begin
                ones_d     = scratch_fin[3:0];
                tens_d     = scratch_fin[7:4];
                hundreds_d = scratch_fin[11:8];
                blank_d    = blank_of(scratch_fin[11:8], scratch_fin[7:4]);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= 8'd0;
            scratch_q  <= 12'd0;
            cnt_q      <= 3'd0;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            hundreds_q <= 4'd0;
            blank_q    <= BLANK_RST;
        end else begin
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            hundreds_q <= hundreds_d;
            blank_q    <= blank_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign hundreds = hundreds_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Testbench for bin2bcd_conv: directed vector table, random values against
// an arithmetic reference, and sequences for ignored starts, mid-conversion
// reset and a back-to-back sweep of all inputs.
module tb_bin2bcd_conv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       busy, done;
    logic [3:0] ones, tens, hundreds;
    logic [2:0] blank;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

`ifdef BIN2BCD_LZB_EN
    localparam logic [2:0] B_HT = 3'b110;
    localparam logic [2:0] B_H  = 3'b100;
`else
    localparam logic [2:0] B_HT = 3'b000;
    localparam logic [2:0] B_H  = 3'b000;
`endif

    typedef struct {
        logic [7:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [2:0] b;
    } vec_t;

    bin2bcd_conv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .blank    (blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by division, blanking from the digit values.
    function automatic logic [14:0] ref_model(input int v);
        logic [3:0] h, t, o;
        logic [2:0] b;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
`ifdef BIN2BCD_LZB_EN
        b = {(h == 0), (h == 0 && t == 0), 1'b0};
`else
        b = 3'b000;
`endif
        return {h, t, o, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    // One conversion from IDLE; checks timing and hold, returns the reported result.
    task automatic run_conv(input logic [7:0] v, output logic [14:0] res);
        int busy_ok;
        busy_ok = 1;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);
        for (int c = 1; c <= 8; c++) begin
            if (!(busy && !done)) busy_ok = 0;
            @(negedge clk);
        end
        chk("busy_window", 32'(busy_ok), 32'd1);
        chk("done_pulse", {30'd0, busy, done}, 32'b01);
        res = {hundreds, tens, ones, blank};
        @(negedge clk);
        chk("hold_after_done", {17'd0, busy, done, hundreds, tens, ones, blank}, {17'd0, 2'b00, res});
    endtask

    initial begin
        vec_t        tbl [8];
        logic [14:0] res;
        logic [14:0] got;
        int          dcount, done_j, v, last, w;

        tbl[0] = '{8'd255, 4'd2, 4'd5, 4'd5, 3'b000};
        tbl[1] = '{8'd0,   4'd0, 4'd0, 4'd0, B_HT};
        tbl[2] = '{8'd9,   4'd0, 4'd0, 4'd9, B_HT};
        tbl[3] = '{8'd100, 4'd1, 4'd0, 4'd0, 3'b000};
        tbl[4] = '{8'd37,  4'd0, 4'd3, 4'd7, B_H};
        tbl[5] = '{8'd199, 4'd1, 4'd9, 4'd9, 3'b000};
        tbl[6] = '{8'd10,  4'd0, 4'd1, 4'd0, B_H};
        tbl[7] = '{8'd128, 4'd1, 4'd2, 4'd8, 3'b000};

        // Reset state.
        #1;
        chk("reset_state", {17'd0, busy, done, hundreds, tens, ones, blank},
            {17'd0, 2'b00, 12'd0, B_HT});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].v, res);
            chk($sformatf("table_%0d", tbl[i].v), {17'd0, res},
                {17'd0, tbl[i].h, tbl[i].t, tbl[i].o, tbl[i].b});
        end

        // Random values against the reference model.
        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 255));
            run_conv(8'(v), res);
            chk($sformatf("rand_%0d", v), {17'd0, res}, {17'd0, ref_model(v)});
        end

        // Starts during SHIFT and DONE are ignored and not queued.
        bin   = 8'd37;
        start = 1'b1;
        @(posedge clk);
        dcount = 0;
        done_j = 0;
        got    = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                done_j = j;
                got = {hundreds, tens, ones, blank};
            end
            start = (j == 3 || j == 9);
            bin   = 8'd200;
        end
        start = 1'b0;
        chk("ignored_start_done_count", 32'(dcount), 32'd1);
        chk("ignored_start_done_cycle", 32'(done_j), 32'd9);
        chk("ignored_start_result", {17'd0, got}, {17'd0, ref_model(37)});
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a conversion.
        run_conv(8'd255, res);
        bin   = 8'd123;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {17'd0, busy, done, hundreds, tens, ones, blank},
            {17'd0, 2'b00, 12'd0, B_HT});
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dcount++;
            if (c == 3) rst_n = 1'b1;
        end
        chk("midreset_no_done", 32'(dcount), 32'd0);
        run_conv(8'd123, res);
        chk("after_reset_123", {17'd0, res}, {17'd0, ref_model(123)});

        // Exhaustive sweep with start held high: results and 10-cycle period.
        v     = 0;
        last  = 0;
        bin   = 8'd0;
        start = 1'b1;
        while (v < 256) begin
            w = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                w++;
                if (done) break;
            end
            if (!done) begin
                chk("sweep_timeout", 32'd0, 32'd1);
                break;
            end
            chk($sformatf("sweep_%0d", v), {17'd0, hundreds, tens, ones, blank},
                {17'd0, ref_model(v)});
            if (v > 0) chk("sweep_period", 32'(cyc - last), 32'd10);
            last = cyc;
            v++;
            bin = 8'(v);
            if (v == 256) start = 1'b0;
        end
        start = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("sweep_end_idle", {30'd0, busy, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
